button_event_arbiter: RTL and testbench

//   Collects trans_up/trans_dn pulses from N_CH debouncer instances and serialises

---
 rtl/button_event_arbiter.sv | 150 +++++++++++++++
 tb/tb_button_event_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/button_event_arbiter.sv
// Purpose : merge per-channel debounced edge pulses (trans_up/trans_dn) into a
//           single ordered event stream, served round-robin through a small FIFO
//           with a valid/ready handshake. Events that cannot be held raise a
//           sticky overflow flag.
// Ports   : CLK, RESETN (async active-low)
//           trans_up/trans_dn [N_CH]  - 1-cycle edge pulses per channel
//           evt_valid/evt_ready       - head-of-FIFO handshake
//           evt_chan, evt_dir         - head event (dir 1 = press, 0 = release)
//           overflow, overflow_clr    - sticky drop flag and its clear pulse
module button_event_arbiter #(
    parameter int unsigned N_CH       = 4,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                    CLK,
    input  logic                    RESETN,
    input  logic [N_CH-1:0]         trans_up,
    input  logic [N_CH-1:0]         trans_dn,
    output logic                    evt_valid,
    input  logic                    evt_ready,
    output logic [$clog2(N_CH)-1:0] evt_chan,
    output logic                    evt_dir,
    output logic                    overflow,
    input  logic                    overflow_clr
);

    localparam int unsigned CW   = $clog2(N_CH);
    localparam int unsigned NS   = 2 * N_CH;
    // Slot index s = 2*ch + dir, so the slot number is itself the {chan,dir} payload.
    localparam int unsigned SW   = CW + 1;
    localparam int unsigned AW   = $clog2(FIFO_DEPTH);
    localparam int unsigned CNTW = AW + 1;

    logic [NS-1:0]   pend_q, pend_d;
    logic [NS-1:0]   pulse;
    logic [NS-1:0]   grant_oh;
    logic [SW-1:0]   ptr_q, ptr_d;
    logic [SW-1:0]   grant_slot;
    logic [SW-1:0]   idx;
    logic            grant_any;
    logic            fifo_full;
    logic            push;
    logic            pop;
    logic            drop;
    logic            overflow_q, overflow_d;

    logic [SW-1:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0] count_q, count_d;
    logic [SW-1:0]   head_d;
    logic            evt_valid_q, evt_valid_d;
    logic [CW-1:0]   evt_chan_q, evt_chan_d;
    logic            evt_dir_q, evt_dir_d;

    // Map channel pulses onto slots.
    always_comb begin
        pulse = '0;
        for (int ch = 0; ch < int'(N_CH); ch++) begin
            pulse[2*ch]     = trans_dn[ch];
            pulse[2*ch + 1] = trans_up[ch];
        end
    end

    // Round-robin search starting one past the last granted slot.
    always_comb begin
        grant_any  = 1'b0;
        grant_slot = '0;
        idx        = '0;
        for (int i = 1; i <= int'(NS); i++) begin
            idx = SW'((int'(ptr_q) + i) % int'(NS));
            if (!grant_any && pend_q[idx]) begin
                grant_any  = 1'b1;
                grant_slot = idx;
            end
        end
    end

    // Grant/capture/overflow bookkeeping; full is judged on the registered count.
    always_comb begin
        fifo_full  = (count_q == CNTW'(FIFO_DEPTH));
        push       = grant_any && !fifo_full;
        grant_oh   = '0;
        if (push) begin
            grant_oh[grant_slot] = 1'b1;
        end
        // A pulse on the slot being granted re-arms it rather than being lost.
        pend_d     = (pend_q & ~grant_oh) | pulse;
        drop       = |(pulse & pend_q & ~grant_oh);
        overflow_d = drop | (overflow_q & ~overflow_clr);
        ptr_d      = push ? grant_slot : ptr_q;
    end

    // FIFO pointers and the registered head view.
    always_comb begin
        pop         = evt_valid_q && evt_ready;
        wr_ptr_d    = wr_ptr_q + AW'(push);
        rd_ptr_d    = rd_ptr_q + AW'(pop);
        count_d     = count_q + CNTW'(push) - CNTW'(pop);
        head_d      = {evt_chan_q, evt_dir_q};
        if (count_d != '0) begin
            // Entry being written this cycle becomes the head when nothing older remains.
            if (push && ((count_q - CNTW'(pop)) == '0)) begin
                head_d = grant_slot;
            end else begin
                head_d = mem_q[rd_ptr_d];
            end
        end
        evt_valid_d = (count_d != '0);
        evt_chan_d  = head_d[SW-1:1];
        evt_dir_d   = head_d[0];
    end

    // Control state.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            pend_q      <= '0;
            ptr_q       <= SW'(NS - 1);
            overflow_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            evt_valid_q <= 1'b0;
            evt_chan_q  <= '0;
            evt_dir_q   <= 1'b0;
        end else begin
            pend_q      <= pend_d;
            ptr_q       <= ptr_d;
            overflow_q  <= overflow_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            evt_valid_q <= evt_valid_d;
            evt_chan_q  <= evt_chan_d;
            evt_dir_q   <= evt_dir_d;
        end
    end

    // FIFO storage; contents are only meaningful below count_q, so no reset.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= grant_slot;
        end
    end

    assign evt_valid = evt_valid_q;
    assign evt_chan  = evt_chan_q;
    assign evt_dir   = evt_dir_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_button_event_arbiter.sv
// Bench for button_event_arbiter: table of single-burst vectors (reset before each,
// consumer always ready) plus hand-written multi-cycle sequences. Expected events
// are queued when stimulus is driven and compared as the DUT hands them out.
module tb_button_event_arbiter;

    localparam int unsigned N_CH       = 4;
    localparam int unsigned FIFO_DEPTH = 4;

    logic       CLK = 1'b0;
    logic       RESETN;
    logic [3:0] trans_up;
    logic [3:0] trans_dn;
    logic       evt_valid;
    logic       evt_ready;
    logic [1:0] evt_chan;
    logic       evt_dir;
    logic       overflow;
    logic       overflow_clr;

    button_event_arbiter #(.N_CH(N_CH), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .CLK         (CLK),
        .RESETN      (RESETN),
        .trans_up    (trans_up),
        .trans_dn    (trans_dn),
        .evt_valid   (evt_valid),
        .evt_ready   (evt_ready),
        .evt_chan    (evt_chan),
        .evt_dir     (evt_dir),
        .overflow    (overflow),
        .overflow_clr(overflow_clr)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [1:0] chan;
        logic       dir;
    } evt_t;

    // seq holds expected slots one per nibble, first event in the lowest nibble.
    typedef struct {
        logic [3:0]  up;
        logic [3:0]  dn;
        int          n;
        logic [31:0] seq;
    } vec_t;

    int   n_checks = 0;
    int   n_pass   = 0;
    evt_t exp_q[$];
    evt_t mon_e;
    vec_t vecs[6];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Scoreboard: an accepted handshake consumes the oldest expected event.
    always @(negedge CLK) begin
        if (RESETN === 1'b1 && evt_valid === 1'b1 && evt_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_event: got chan=%0d dir=%0d, expected no event",
                         evt_chan, evt_dir);
            end else begin
                mon_e = exp_q.pop_front();
                check("evt_chan", int'(evt_chan), int'(mon_e.chan));
                check("evt_dir", int'(evt_dir), int'(mon_e.dir));
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic push_exp(input int slot);
        exp_q.push_back(evt_t'({2'(slot >> 1), 1'(slot & 1)}));
    endtask

    task automatic pulse(input logic [3:0] up, input logic [3:0] dn);
        trans_up = up;
        trans_dn = dn;
        tick(1);
        trans_up = '0;
        trans_dn = '0;
    endtask

    task automatic do_reset();
        RESETN       = 1'b0;
        exp_q.delete();
        trans_up     = '0;
        trans_dn     = '0;
        overflow_clr = 1'b0;
        tick(2);
        RESETN = 1'b1;
        tick(1);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick(1);
            n++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain_timeout: %0d events still outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
        tick(3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{up: 4'b0100, dn: 4'b0000, n: 1, seq: 32'h0000_0005};
        vecs[1] = '{up: 4'b1111, dn: 4'b0000, n: 4, seq: 32'h0000_7531};
        vecs[2] = '{up: 4'b0000, dn: 4'b1010, n: 2, seq: 32'h0000_0062};
        vecs[3] = '{up: 4'b1001, dn: 4'b1001, n: 4, seq: 32'h0000_7610};
        vecs[4] = '{up: 4'b1111, dn: 4'b1111, n: 8, seq: 32'h7654_3210};
        vecs[5] = '{up: 4'b0000, dn: 4'b0010, n: 1, seq: 32'h0000_0002};

        RESETN       = 1'b0;
        trans_up     = '0;
        trans_dn     = '0;
        evt_ready    = 1'b0;
        overflow_clr = 1'b0;
        tick(2);
        check("reset_valid", int'(evt_valid), 0);
        check("reset_chan", int'(evt_chan), 0);
        check("reset_dir", int'(evt_dir), 0);
        check("reset_overflow", int'(overflow), 0);

        // Latency: pulse captured at edge t, valid after t+1, consumed at t+2.
        do_reset();
        evt_ready = 1'b1;
        push_exp(5);
        pulse(4'b0100, 4'b0000);
        check("lat_valid_t", int'(evt_valid), 0);
        tick(1);
        check("lat_valid_t1", int'(evt_valid), 1);
        check("lat_chan_t1", int'(evt_chan), 2);
        check("lat_dir_t1", int'(evt_dir), 1);
        tick(1);
        check("lat_valid_t2", int'(evt_valid), 0);
        drain(10);

        // Table: single burst after reset, consumer always ready.
        for (int v = 0; v < 6; v++) begin
            do_reset();
            evt_ready = 1'b1;
            for (int k = 0; k < vecs[v].n; k++) begin
                push_exp(int'((vecs[v].seq >> (4 * k)) & 32'hF));
            end
            pulse(vecs[v].up, vecs[v].dn);
            drain(40);
            check("vec_valid_idle", int'(evt_valid), 0);
            check("vec_overflow", int'(overflow), 0);
        end

        // Six slots while stalled: four fill the FIFO, two wait in pending bits.
        do_reset();
        evt_ready = 1'b0;
        for (int s = 0; s < 6; s++) push_exp(s);
        pulse(4'b0111, 4'b0111);
        tick(8);
        check("stall_valid", int'(evt_valid), 1);
        check("stall_head_chan", int'(evt_chan), 0);
        check("stall_head_dir", int'(evt_dir), 0);
        check("stall_overflow", int'(overflow), 0);
        tick(3);
        check("stall_head_stable", int'({evt_chan, evt_dir}), 0);
        evt_ready = 1'b1;
        drain(40);
        check("stall_overflow_end", int'(overflow), 0);

        // Overflow: duplicate pulse on a slot blocked by a full FIFO.
        do_reset();
        evt_ready = 1'b0;
        pulse(4'b1111, 4'b0000);
        tick(6);
        check("ovf_fifo_full_valid", int'(evt_valid), 1);
        pulse(4'b0000, 4'b0010);
        check("ovf_first_pulse", int'(overflow), 0);
        pulse(4'b0000, 4'b0010);
        check("ovf_second_pulse", int'(overflow), 1);
        overflow_clr = 1'b1;
        tick(1);
        overflow_clr = 1'b0;
        check("ovf_cleared", int'(overflow), 0);
        overflow_clr = 1'b1;
        pulse(4'b0000, 4'b0010);
        overflow_clr = 1'b0;
        check("ovf_set_wins", int'(overflow), 1);
        overflow_clr = 1'b1;
        tick(1);
        overflow_clr = 1'b0;
        check("ovf_cleared_again", int'(overflow), 0);
        push_exp(1); push_exp(3); push_exp(5); push_exp(7); push_exp(2);
        evt_ready = 1'b1;
        drain(40);

        // Fairness: slot 0 pulses every cycle, slot 5 once; slot 5 slips in third.
        do_reset();
        evt_ready = 1'b1;
        push_exp(0); push_exp(0); push_exp(5);
        for (int k = 0; k < 17; k++) push_exp(0);
        for (int k = 1; k <= 20; k++) begin
            trans_dn = 4'b0001;
            trans_up = (k == 3) ? 4'b0100 : 4'b0000;
            tick(1);
        end
        trans_dn = '0;
        trans_up = '0;
        drain(60);
        check("fair_overflow", int'(overflow), 1);

        // Asynchronous reset with events queued and overflow set.
        do_reset();
        evt_ready = 1'b0;
        pulse(4'b0111, 4'b0000);
        pulse(4'b0100, 4'b0000);
        tick(5);
        check("prerst_valid", int'(evt_valid), 1);
        check("prerst_overflow", int'(overflow), 1);
        #2;
        RESETN = 1'b0;
        exp_q.delete();
        #1;
        check("rst_async_valid", int'(evt_valid), 0);
        check("rst_async_overflow", int'(overflow), 0);
        tick(1);
        pulse(4'b1000, 4'b0000);
        RESETN = 1'b1;
        tick(3);
        check("postrst_valid", int'(evt_valid), 0);
        check("postrst_overflow", int'(overflow), 0);
        evt_ready = 1'b1;
        push_exp(6);
        pulse(4'b0000, 4'b1000);
        drain(20);
        check("postrst_overflow_end", int'(overflow), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
